// File: rtl/div_seq8_pkg.sv
// Shared ALU definitions for the sequential divider: FSM states, default
// operand width and the iteration-counter width helper.
package div_seq8_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 8;

  // Bits needed to count 0..w (ceil(log2(w+1))).
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_seq8_sub_stage.sv
// One restoring-division step: T = S - {0,D} as S + ~D + 1 on a
// WIDTH+2-bit carry-lookahead adder. The MSB of T is the borrow; on
// borrow the shifted remainder is kept, otherwise T is taken and the
// quotient bit is 1.
module div_sub_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  localparam int N = WIDTH + 2;

  logic [N-1:0] a, b, g, p, c, t;
  logic         term;

  assign a = {1'b0, s};
  assign b = ~{2'b00, d};
  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (p[0..i] & cin), cin = 1.
  always_comb begin
    c    = '0;
    term = 1'b0;
    c[0] = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
      term = 1'b1;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = c[i+1] | term;
    end
  end

  assign t      = p ^ c;
  assign q_bit  = ~t[N-1];
  assign r_next = t[N-1] ? s : t[WIDTH:0];

endmodule

// File: rtl/div_seq8.sv
// Sequential radix-2 restoring divider: one quotient bit per clock through a
// single shared subtract stage. start/done handshake; divide-by-zero
// completes in one cycle without iterating.
module div_seq8
  import div_seq8_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  div_state_e       state, state_nx;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   r_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  // R never exceeds D after a restoring step, so its MSB is never consumed.
  logic             unused_r_msb;
  assign unused_r_msb = r[WIDTH];

  assign s      = {r[WIDTH-1:0], q[WIDTH-1]};
  assign q_next = {q[WIDTH-2:0], q_bit};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .s      (s),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nx;
  end

  // Next state; busy/done decode from registered state only.
  always_comb begin
    state_nx = state;
    busy     = (state == DIV_RUN);
    done     = (state == DIV_DONE);
    case (state)
      DIV_IDLE: if (start) state_nx = (divisor != '0) ? DIV_RUN : DIV_DONE;
      DIV_RUN:  if (cnt == LAST) state_nx = DIV_DONE;
      DIV_DONE: state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
  end

  // Datapath: operand load, iteration, and result capture on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r   <= '0;
              q   <= dividend;
              d   <= divisor;
              cnt <= '0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        DIV_RUN: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq8.sv
// Directed and randomized checks for div_seq8 at WIDTH=8.
module tb_div_seq8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         n;     // edges from accept to first done
    int         bcnt;  // cycles with busy high
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q_o, output logic [7:0] r_o,
                        output logic z_o, output int n, output int bcnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; n = 0; bcnt = 0;
    while (!done && n < 40) begin
      bcnt += int'(busy);
      @(negedge clk);
      n++;
    end
    q_o = quotient; r_o = remainder; z_o = div_by_zero;
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 0);
  endtask

  vec_t       tab [7];
  logic [7:0] q_o, r_o;
  logic       z_o;
  int         n, bcnt, dseen;

  initial begin
    tab[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8, 8};
    tab[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8, 8};
    tab[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8, 8};
    tab[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8, 8};
    tab[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8, 8};
    tab[5] = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1, 0, 0};
    tab[6] = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0, 8, 8};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_quot", 32'(quotient), 0);
    chk("rst_rem",  32'(remainder), 0);
    chk("rst_dbz",  32'(div_by_zero), 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(tab[i].a, tab[i].b, q_o, r_o, z_o, n, bcnt);
      chk($sformatf("v%0d_quot", i), 32'(q_o), 32'(tab[i].q));
      chk($sformatf("v%0d_rem", i),  32'(r_o), 32'(tab[i].r));
      chk($sformatf("v%0d_dbz", i),  32'(z_o), 32'(tab[i].z));
      chk($sformatf("v%0d_lat", i),  32'(n),   32'(tab[i].n));
      chk($sformatf("v%0d_busy", i), 32'(bcnt), 32'(tab[i].bcnt));
    end

    // Start while busy: 50/5 with a 99/2 start pulse on cycle 3
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0; n = 0;
    while (!done && n < 40) begin
      if (n == 2) begin
        start = 1'b1; dividend = 8'd99; divisor = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (n == 4) chk("run_hold_quot", 32'(quotient), 10);
      @(negedge clk);
      n++;
    end
    chk("busy_start_lat",  32'(n), 8);
    chk("busy_start_quot", 32'(quotient), 10);
    chk("busy_start_rem",  32'(remainder), 0);

    // Start held through DONE is ignored; accepted in the following IDLE
    start = 1'b1; dividend = 8'd99; divisor = 8'd2;
    @(negedge clk);
    chk("done_start_busy", 32'(busy), 0);
    chk("done_start_done", 32'(done), 0);
    chk("done_start_quot", 32'(quotient), 10);
    @(negedge clk);
    chk("idle_start_busy", 32'(busy), 1);
    start = 1'b0; n = 0;
    while (!done && n < 40) begin
      if (n == 3) chk("run_prev_quot", 32'(quotient), 10);
      @(negedge clk);
      n++;
    end
    chk("held_lat",  32'(n), 8);
    chk("held_quot", 32'(quotient), 49);
    chk("held_rem",  32'(remainder), 1);
    @(negedge clk);

    // Reset during cycle 4 of 123/10
    @(negedge clk);
    start = 1'b1; dividend = 8'd123; divisor = 8'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_quot", 32'(quotient), 0);
    chk("midrst_rem",  32'(remainder), 0);
    chk("midrst_dbz",  32'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    dseen = 0;
    repeat (12) begin
      @(negedge clk);
      dseen += int'(done);
    end
    chk("midrst_no_done", 32'(dseen), 0);
    run_op(8'd123, 8'd10, q_o, r_o, z_o, n, bcnt);
    chk("post_rst_quot", 32'(q_o), 12);
    chk("post_rst_rem",  32'(r_o), 3);
    chk("post_rst_lat",  32'(n), 8);

    // Random pairs against arithmetic model and the division invariant
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(a, b, q_o, r_o, z_o, n, bcnt);
      if (b == 0) begin
        chk("rnd_dbz_quot", 32'(q_o), 255);
        chk("rnd_dbz_rem",  32'(r_o), 32'(a));
        chk("rnd_dbz_flag", 32'(z_o), 1);
        chk("rnd_dbz_lat",  32'(n), 0);
      end else begin
        chk("rnd_quot", 32'(q_o), 32'(a / b));
        chk("rnd_rem",  32'(r_o), 32'(a % b));
        chk("rnd_inv",  32'((32'(q_o) * 32'(b) + 32'(r_o) == 32'(a)) && (r_o < b)), 1);
        chk("rnd_lat",  32'(n), 8);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
